// File: rtl/key_debounce_if.sv
// Key panel bundle: raw active-low buttons and repeat enable in, set pulses and levels out.
interface key_debounce_if;
  logic sw_hour;
  logic sw_min;
  logic repeat_en;
  logic hour_pulse;
  logic min_pulse;
  logic hour_level;
  logic min_level;

  modport master (
    output sw_hour, sw_min, repeat_en,
    input  hour_pulse, min_pulse, hour_level, min_level
  );

  modport slave (
    input  sw_hour, sw_min, repeat_en,
    output hour_pulse, min_pulse, hour_level, min_level
  );
endinterface

// File: rtl/key_debounce.sv
// Two independent debounce/auto-repeat channels; press pulse DB_CYCLES+2 edges after the raw low.
// Outputs are free-running set requests with no backpressure; the consumer must take every pulse.
module key_debounce_ch #(
  parameter int DB_CYCLES     = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 10000000,
  parameter int CW            = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_n_i,
  input  logic repeat_en_i,
  output logic pulse_o,
  output logic level_o
);
  typedef enum logic [2:0] {IDLE, PRESS_CHK, HELD, REPEAT, REL_CHK} state_t;

  localparam logic [CW-1:0] DB_C = CW'(DB_CYCLES);
  localparam logic [CW-1:0] RD_C = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] RP_C = CW'(REPEAT_PERIOD);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic          sync1_q, sync2_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CW-1:0] hcnt_q, hcnt_d, hcnt_inc;
  logic          pulse_q, pulse_d;
  logic          fire;
  logic          pressed;

  // Synchronizer resets to the released level so a held key is debounced afresh.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= sw_n_i;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hcnt_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pressed  = ~sync2_q;
  assign cnt_inc  = (cnt_q == '1)  ? cnt_q  : cnt_q + ONE;
  assign hcnt_inc = (hcnt_q == '1) ? hcnt_q : hcnt_q + ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    fire    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        hcnt_d = '0;
        if (pressed) begin
          if (ONE >= DB_C) begin
            state_d = HELD;
            fire    = 1'b1;
          end else begin
            state_d = PRESS_CHK;
            cnt_d   = ONE;
          end
        end
      end
      PRESS_CHK: begin
        if (!pressed) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_inc >= DB_C) begin
          state_d = HELD;
          fire    = 1'b1;
          cnt_d   = '0;
          hcnt_d  = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD, REPEAT: begin
        if (!pressed) begin
          hcnt_d = '0;
          if (ONE >= DB_C) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = REL_CHK;
            cnt_d   = ONE;
          end
        end else if (!repeat_en_i) begin
          // Dropping the enable parks in HELD so re-enabling waits the full delay again.
          state_d = HELD;
          hcnt_d  = '0;
        end else if (hcnt_inc >= ((state_q == HELD) ? RD_C : RP_C)) begin
          state_d = REPEAT;
          fire    = 1'b1;
          hcnt_d  = '0;
        end else begin
          hcnt_d = hcnt_inc;
        end
      end
      REL_CHK: begin
        if (pressed) begin
          state_d = HELD;
          cnt_d   = '0;
          hcnt_d  = '0;
        end else if (cnt_inc >= DB_C) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        hcnt_d  = '0;
      end
    endcase
  end

  always_comb begin
    pulse_d = fire;
    level_o = (state_q == HELD) || (state_q == REPEAT) || (state_q == REL_CHK);
  end

  assign pulse_o = pulse_q;
endmodule

module key_debounce #(
  parameter int DB_CYCLES     = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input logic          clk,
  input logic          rst,
  key_debounce_if.slave kb
);
  localparam int MAX_DR = (DB_CYCLES > REPEAT_DELAY) ? DB_CYCLES : REPEAT_DELAY;
  localparam int MAXP   = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
  localparam int CW     = $clog2(MAXP + 1);

  key_debounce_ch #(
    .DB_CYCLES(DB_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD), .CW(CW)
  ) u_hour (
    .clk(clk), .rst(rst), .sw_n_i(kb.sw_hour), .repeat_en_i(kb.repeat_en),
    .pulse_o(kb.hour_pulse), .level_o(kb.hour_level)
  );

  key_debounce_ch #(
    .DB_CYCLES(DB_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD), .CW(CW)
  ) u_min (
    .clk(clk), .rst(rst), .sw_n_i(kb.sw_min), .repeat_en_i(kb.repeat_en),
    .pulse_o(kb.min_pulse), .level_o(kb.min_level)
  );
endmodule
